// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C role arbiter and the engines that
// consume its mux select.
package i2c_pkg;

    typedef enum logic [2:0] {
        FREE_WAIT = 3'd0,
        IDLE      = 3'd1,
        MASTER    = 3'd2,
        SLAVE_ACT = 3'd3,
        LOST      = 3'd4
    } arb_state_t;

    localparam logic MS_MASTER = 1'b0;
    localparam logic MS_SLAVE  = 1'b1;

    // Saturating increment used by every arbiter counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic [15:0] max_value);
        logic [15:0] result;
        if (value == max_value) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/i2c_cond_detect.sv
// START/STOP/SCL-rise detector on synchronised bus lines; every pulse is
// registered and appears one clock after the sampled edge.
module i2c_cond_detect (
    input  logic clk,
    input  logic rst,
    input  logic sda,
    input  logic scl,
    output logic start_det,
    output logic stop_det,
    output logic scl_rise
);

    logic sda_prev_r;
    logic scl_prev_r;
    logic start_r;
    logic stop_r;
    logic rise_r;
    logic start_s;
    logic stop_s;
    logic rise_s;

    // Previous-line registers idle high so a released bus yields no false START.
    assign start_s = scl_prev_r & scl & sda_prev_r & ~sda;
    assign stop_s  = scl_prev_r & scl & ~sda_prev_r & sda;
    assign rise_s  = ~scl_prev_r & scl;

    // Line history and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sda_prev_r <= 1'b1;
            scl_prev_r <= 1'b1;
            start_r    <= 1'b0;
            stop_r     <= 1'b0;
            rise_r     <= 1'b0;
        end else begin
            sda_prev_r <= sda;
            scl_prev_r <= scl;
            start_r    <= start_s;
            stop_r     <= stop_s;
            rise_r     <= rise_s;
        end
    end

    assign start_det = start_r;
    assign stop_det  = stop_r;
    assign scl_rise  = rise_r;

endmodule

// File: rtl/i2c_role_arbiter.sv
// Chooses whether the master or slave engine owns the shared I2C datapath,
// qualifying the bus as free and recovering from arbitration loss or SCL stuck low.
module i2c_role_arbiter
    import i2c_pkg::*;
#(
    parameter int BUS_FREE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int CNT_W           = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic SDA_sync,
    input  logic SCL_sync,
    input  logic master_req,
    input  logic master_SDA_out,
    output logic ms_select,
    output logic master_grant,
    output logic bus_busy,
    output logic start_det,
    output logic stop_det,
    output logic arb_lost,
    output logic timeout
);

    localparam logic [CNT_W-1:0] FREE_LAST = CNT_W'(BUS_FREE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    arb_state_t       state_r, next_state_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
    logic             started_r, started_nxt_s;
    logic             ms_select_r, master_grant_r, bus_busy_r, arb_lost_r, timeout_r;
    logic             arb_s, to_s, busy_nxt_s;
    logic             start_s, stop_s, rise_s, line_free_s;

    i2c_cond_detect u_cond (
        .clk       (clk),
        .rst       (rst),
        .sda       (SDA_sync),
        .scl       (SCL_sync),
        .start_det (start_s),
        .stop_det  (stop_s),
        .scl_rise  (rise_s)
    );

    assign line_free_s = SDA_sync & SCL_sync;
    assign cnt_inc_s   = CNT_W'(sat_inc16(16'(cnt_r), 16'(CNT_MAX)));

    // Next-state, shared counter and pulse decisions.
    always_comb begin
        next_state_s  = state_r;
        cnt_nxt_s     = cnt_r;
        started_nxt_s = 1'b0;
        arb_s         = 1'b0;
        to_s          = 1'b0;
        case (state_r)
            FREE_WAIT: begin
                if (start_s) begin
                    next_state_s = SLAVE_ACT;
                end else if (!line_free_s) begin
                    cnt_nxt_s = '0;
                end else if (cnt_r == FREE_LAST) begin
                    next_state_s = IDLE;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            IDLE: begin
                if (start_s) begin
                    next_state_s = SLAVE_ACT;
                end else if (master_req) begin
                    next_state_s = MASTER;
                end else begin
                    next_state_s = IDLE;
                end
            end
            MASTER, SLAVE_ACT, LOST: begin
                if (stop_s) begin
                    next_state_s = FREE_WAIT;
                end else if (!SCL_sync && (cnt_r == TO_LAST)) begin
                    to_s         = 1'b1;
                    next_state_s = FREE_WAIT;
                end else begin
                    cnt_nxt_s = SCL_sync ? '0 : cnt_inc_s;
                    if (state_r != MASTER) begin
                        next_state_s = state_r;
                    end else if (rise_s && master_SDA_out && !SDA_sync) begin
                        arb_s        = 1'b1;
                        next_state_s = LOST;
                    end else if (!started_r && !start_s && !master_req) begin
                        next_state_s = IDLE;
                    end else begin
                        started_nxt_s = started_r | start_s;
                    end
                end
            end
            default: begin
                next_state_s = FREE_WAIT;
                cnt_nxt_s    = '0;
            end
        endcase
        // Any state change restarts the shared counter.
        if (next_state_s != state_r) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_nxt_s;
        end
        case (next_state_s)
            IDLE:    busy_nxt_s = 1'b0;
            MASTER:  busy_nxt_s = started_nxt_s;
            default: busy_nxt_s = 1'b1;
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= FREE_WAIT;
            cnt_r          <= '0;
            started_r      <= 1'b0;
            ms_select_r    <= MS_SLAVE;
            master_grant_r <= 1'b0;
            bus_busy_r     <= 1'b1;
            arb_lost_r     <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            cnt_r          <= cnt_nxt_s;
            started_r      <= started_nxt_s;
            ms_select_r    <= (next_state_s == MASTER) ? MS_MASTER : MS_SLAVE;
            master_grant_r <= (next_state_s == MASTER);
            bus_busy_r     <= busy_nxt_s;
            arb_lost_r     <= arb_s;
            timeout_r      <= to_s;
        end
    end

    assign ms_select    = ms_select_r;
    assign master_grant = master_grant_r;
    assign bus_busy     = bus_busy_r;
    assign start_det    = start_s;
    assign stop_det     = stop_s;
    assign arb_lost     = arb_lost_r;
    assign timeout      = timeout_r;

endmodule
